phys_reg_ready_table_mp: RTL and testbench
==========================================

Name: phys_reg_ready_table_mp

Overview:
Parametrised multi-way successor to the 2-source/1-dest physical register ready table. It tracks one ready bit per physical register. It serves DISPATCH_WAYS dispatch slots per cycle, each with two source reads and one dest clear, and takes NUM_COMPLETE_BUSES completion sets. It adds same-cycle bypass and branch checkpoint save/restore for mispredict recovery. It sits in the core between rename/dispatch and the reservation stations.

Parameters:
NUM_PHYS_REGS, 64, physical register count; tag width TW = $clog2(NUM_PHYS_REGS)
DISPATCH_WAYS, 2, dispatch slots per cycle; way 0 oldest
NUM_COMPLETE_BUSES, 2, completion buses setting ready bits
NUM_CHECKPOINTS, 4, snapshot slots; index width CW = $clog2(NUM_CHECKPOINTS)

Ports:
CLK  in  1  clock, posedge
nRST  in  1  reset, synchronous, active-high (nRST=1 resets on posedge CLK)
DUT_error  out  1  registered protocol-violation flag
dispatch_source_0_phys_reg_tag  in  DISPATCH_WAYS*TW  per-way source 0 tag
dispatch_source_0_ready  out  DISPATCH_WAYS  per-way source 0 ready, combinational
dispatch_source_1_phys_reg_tag  in  DISPATCH_WAYS*TW  per-way source 1 tag
dispatch_source_1_ready  out  DISPATCH_WAYS  per-way source 1 ready, combinational
dispatch_dest_write  in  DISPATCH_WAYS  per-way clear enable
dispatch_dest_phys_reg_tag  in  DISPATCH_WAYS*TW  per-way dest tag to clear
complete_bus_valid  in  NUM_COMPLETE_BUSES  per-bus valid
complete_bus_dest_phys_reg_tag  in  NUM_COMPLETE_BUSES*TW  per-bus dest tag to set
checkpoint_save_valid  in  1  snapshot post-update table into slot
checkpoint_save_index  in  CW  slot to write
checkpoint_restore_valid  in  1  mispredict: restore from slot
checkpoint_restore_index  in  CW  slot to read

Behaviour:
- Reset (nRST=1 at posedge): all table bits = 1. All checkpoint slots = all-ones and marked invalid. DUT_error = 0. Outputs reflect table combinationally, so ready = 1 the cycle after reset with any tags.
- Source read, way w, source s, tag t: ready = table[t] OR (any valid complete bus with tag t this cycle), AND NOT (any way v<w with dest_write and dest tag t). A way's own dest clear does not affect its own sources.
- Table next-state: set bits from complete buses, then clear bits from dispatch dests. Clear wins over set on the same tag (newly allocated dest).
- Checkpoint save: slot[idx] <= table next-state; slot marked valid.
- Every valid complete bus also sets its bit in every checkpoint slot in the same cycle, so snapshots stay current.
- Restore (valid, slot valid): table <= slot[idx] OR this cycle's completions. All dispatch clears and any save in the same cycle are ignored. Read outputs are unaffected. Restored slot stays valid.
- DUT_error next cycle = 1 if any of:
  - restore to an invalid slot; the table then holds its value
  - two dispatch ways clear the same tag in one cycle
  - two valid complete buses carry the same tag in one cycle
- Otherwise DUT_error = 0; it pulses and is not sticky.
- No internal latency on reads; all state updates are visible the next cycle.

Test Plan:
- Reset then release, all tags 0 -> every source_ready = 1, DUT_error = 0.
- Way0 dest_write tag 5; next cycle way0/way1 source_0 tag 5 -> ready 0/0. Then bus0 valid tag 5 -> same-cycle read ready 1, and ready stays 1 after.
- Same cycle: way0 clears tag 9, way1 source_1 tag 9 -> way1 ready 0, while way0 source_0 tag 9 -> 1. Bus1 sets 9 and way0 clears 9 together -> table[9] = 0 next cycle.
- Clear 12; save slot 2; clear 13; bus0 completes 12; restore slot 2 -> table[12] = 1, table[13] = 1. A dispatch clear of 14 in the restore cycle leaves 14 = 1.
- Restore slot 3 never saved -> DUT_error = 1 the next cycle only, table unchanged.
- Buses 0 and 1 both tag 7 -> DUT_error = 1 next cycle, and table[7] = 1.

Source files
------------

// File: rtl/phys_reg_ready_table_mp.sv
// ---------------------------------------------------------------------------
// phys_reg_ready_table_mp
//
// Multi-way physical register ready table. One ready bit per physical
// register, read by DISPATCH_WAYS dispatch slots (two sources each), cleared
// by each slot's newly allocated destination, and set by NUM_COMPLETE_BUSES
// completion buses. Branch checkpoints snapshot the table so a mispredict can
// roll the ready state back in a single cycle.
//
// Ports:
//   CLK                              clock, rising edge
//   nRST                             synchronous reset, active-high
//   DUT_error                        registered protocol-violation pulse
//   dispatch_source_0/1_phys_reg_tag per-way source tags (packed, way 0 low)
//   dispatch_source_0/1_ready        per-way source ready, combinational
//   dispatch_dest_write              per-way destination clear enable
//   dispatch_dest_phys_reg_tag       per-way destination tag to clear
//   complete_bus_valid               per-bus completion valid
//   complete_bus_dest_phys_reg_tag   per-bus completed tag to mark ready
//   checkpoint_save_valid/index      snapshot the post-update table into a slot
//   checkpoint_restore_valid/index   mispredict: reload the table from a slot
// ---------------------------------------------------------------------------
module phys_reg_ready_table_mp #(
    parameter int NUM_PHYS_REGS      = 64,
    parameter int DISPATCH_WAYS      = 2,
    parameter int NUM_COMPLETE_BUSES = 2,
    parameter int NUM_CHECKPOINTS    = 4,
    localparam int TW                = $clog2(NUM_PHYS_REGS),
    localparam int CW                = $clog2(NUM_CHECKPOINTS)
) (
    input  logic                            CLK,
    input  logic                            nRST,
    output logic                            DUT_error,
    input  logic [DISPATCH_WAYS*TW-1:0]      dispatch_source_0_phys_reg_tag,
    output logic [DISPATCH_WAYS-1:0]         dispatch_source_0_ready,
    input  logic [DISPATCH_WAYS*TW-1:0]      dispatch_source_1_phys_reg_tag,
    output logic [DISPATCH_WAYS-1:0]         dispatch_source_1_ready,
    input  logic [DISPATCH_WAYS-1:0]         dispatch_dest_write,
    input  logic [DISPATCH_WAYS*TW-1:0]      dispatch_dest_phys_reg_tag,
    input  logic [NUM_COMPLETE_BUSES-1:0]    complete_bus_valid,
    input  logic [NUM_COMPLETE_BUSES*TW-1:0] complete_bus_dest_phys_reg_tag,
    input  logic                            checkpoint_save_valid,
    input  logic [CW-1:0]                   checkpoint_save_index,
    input  logic                            checkpoint_restore_valid,
    input  logic [CW-1:0]                   checkpoint_restore_index
);

    logic [NUM_PHYS_REGS-1:0] ready_table;
    logic [NUM_PHYS_REGS-1:0] table_next;
    logic [NUM_PHYS_REGS-1:0] complete_mask;
    logic [NUM_PHYS_REGS-1:0] clear_mask;
    logic [NUM_PHYS_REGS-1:0] checkpoint_table [NUM_CHECKPOINTS];
    logic [NUM_CHECKPOINTS-1:0] checkpoint_valid;

    logic restore_hit;
    logic restore_bad;
    logic dup_clear;
    logic dup_bus;
    logic error_next;

    // One-hot union of every tag broadcast by a valid completion bus.
    always_comb begin
        complete_mask = '0;
        for (int b = 0; b < NUM_COMPLETE_BUSES; b++) begin
            if (complete_bus_valid[b]) begin
                complete_mask[complete_bus_dest_phys_reg_tag[b*TW +: TW]] = 1'b1;
            end
        end
    end

    // Source reads walk the ways oldest first. "older" accumulates the dest
    // clears of earlier ways only, so a way never sees its own clear but does
    // see that an older instruction in the same group reallocated the tag.
    always_comb begin
        logic [NUM_PHYS_REGS-1:0] older;
        older                   = '0;
        dispatch_source_0_ready = '0;
        dispatch_source_1_ready = '0;
        for (int w = 0; w < DISPATCH_WAYS; w++) begin
            dispatch_source_0_ready[w] =
                (ready_table[dispatch_source_0_phys_reg_tag[w*TW +: TW]] |
                 complete_mask[dispatch_source_0_phys_reg_tag[w*TW +: TW]]) &
                ~older[dispatch_source_0_phys_reg_tag[w*TW +: TW]];
            dispatch_source_1_ready[w] =
                (ready_table[dispatch_source_1_phys_reg_tag[w*TW +: TW]] |
                 complete_mask[dispatch_source_1_phys_reg_tag[w*TW +: TW]]) &
                ~older[dispatch_source_1_phys_reg_tag[w*TW +: TW]];
            if (dispatch_dest_write[w]) begin
                older[dispatch_dest_phys_reg_tag[w*TW +: TW]] = 1'b1;
            end
        end
        clear_mask = older;
    end

    // Protocol checks: duplicate dest clears and duplicate completion tags.
    always_comb begin
        dup_clear = 1'b0;
        dup_bus   = 1'b0;
        for (int i = 0; i < DISPATCH_WAYS; i++) begin
            for (int j = i + 1; j < DISPATCH_WAYS; j++) begin
                if (dispatch_dest_write[i] && dispatch_dest_write[j] &&
                    (dispatch_dest_phys_reg_tag[i*TW +: TW] ==
                     dispatch_dest_phys_reg_tag[j*TW +: TW])) begin
                    dup_clear = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_COMPLETE_BUSES; i++) begin
            for (int j = i + 1; j < NUM_COMPLETE_BUSES; j++) begin
                if (complete_bus_valid[i] && complete_bus_valid[j] &&
                    (complete_bus_dest_phys_reg_tag[i*TW +: TW] ==
                     complete_bus_dest_phys_reg_tag[j*TW +: TW])) begin
                    dup_bus = 1'b1;
                end
            end
        end
    end

    // Table next state. A good restore replaces the table (plus this cycle's
    // completions, which the snapshot would otherwise miss); a restore to a
    // never-saved slot freezes the table. Otherwise set then clear, so a
    // freshly allocated dest wins over a stale completion of the same tag.
    always_comb begin
        restore_hit = checkpoint_restore_valid &  checkpoint_valid[checkpoint_restore_index];
        restore_bad = checkpoint_restore_valid & ~checkpoint_valid[checkpoint_restore_index];
        if (restore_hit) begin
            table_next = checkpoint_table[checkpoint_restore_index] | complete_mask;
        end else if (restore_bad) begin
            table_next = ready_table;
        end else begin
            table_next = (ready_table | complete_mask) & ~clear_mask;
        end
        error_next = restore_bad | dup_clear | dup_bus;
    end

    // Live table and error flag.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            ready_table <= '1;
            DUT_error   <= 1'b0;
        end else begin
            ready_table <= table_next;
            DUT_error   <= error_next;
        end
    end

    // Checkpoint slots absorb every completion so a later restore does not
    // lose results that landed after the snapshot. Any restore in flight
    // takes priority over a save in the same cycle.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            for (int c = 0; c < NUM_CHECKPOINTS; c++) begin
                checkpoint_table[c] <= '1;
            end
            checkpoint_valid <= '0;
        end else begin
            for (int c = 0; c < NUM_CHECKPOINTS; c++) begin
                if (checkpoint_save_valid && !checkpoint_restore_valid &&
                    (checkpoint_save_index == CW'(c))) begin
                    checkpoint_table[c] <= table_next;
                    checkpoint_valid[c] <= 1'b1;
                end else begin
                    checkpoint_table[c] <= checkpoint_table[c] | complete_mask;
                end
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_ready_table_mp.sv
// ---------------------------------------------------------------------------
// tb_phys_reg_ready_table_mp
//
// Directed scenarios with literal expectations, then randomized traffic, all
// compared every cycle against a bit-array model of the ready table and its
// checkpoint slots.
// ---------------------------------------------------------------------------
module tb_phys_reg_ready_table_mp;

    localparam int NPR = 64;
    localparam int DW  = 2;
    localparam int NB  = 2;
    localparam int NC  = 4;
    localparam int TW  = 6;
    localparam int CW  = 2;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            DUT_error;
    logic [DW*TW-1:0] src0_tag;
    logic [DW-1:0]    src0_ready;
    logic [DW*TW-1:0] src1_tag;
    logic [DW-1:0]    src1_ready;
    logic [DW-1:0]    dest_write;
    logic [DW*TW-1:0] dest_tag;
    logic [NB-1:0]    bus_valid;
    logic [NB*TW-1:0] bus_tag;
    logic            save_valid;
    logic [CW-1:0]   save_index;
    logic            restore_valid;
    logic [CW-1:0]   restore_index;

    always #5 CLK = ~CLK;

    phys_reg_ready_table_mp #(
        .NUM_PHYS_REGS(NPR),
        .DISPATCH_WAYS(DW),
        .NUM_COMPLETE_BUSES(NB),
        .NUM_CHECKPOINTS(NC)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .DUT_error(DUT_error),
        .dispatch_source_0_phys_reg_tag(src0_tag),
        .dispatch_source_0_ready(src0_ready),
        .dispatch_source_1_phys_reg_tag(src1_tag),
        .dispatch_source_1_ready(src1_ready),
        .dispatch_dest_write(dest_write),
        .dispatch_dest_phys_reg_tag(dest_tag),
        .complete_bus_valid(bus_valid),
        .complete_bus_dest_phys_reg_tag(bus_tag),
        .checkpoint_save_valid(save_valid),
        .checkpoint_save_index(save_index),
        .checkpoint_restore_valid(restore_valid),
        .checkpoint_restore_index(restore_index)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 0;

    // Reference model state.
    bit m_table [NPR];
    bit m_ckpt  [NC][NPR];
    bit m_valid [NC];
    bit m_err;
    bit comp    [NPR];
    bit nxt     [NPR];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected readiness of a tag as seen by dispatch way w this cycle.
    function automatic bit expReady(input int w, input int tag);
        bit r;
        r = m_table[tag];
        for (int b = 0; b < NB; b++)
            if (bus_valid[b] && int'(bus_tag[b*TW +: TW]) == tag) r = 1;
        for (int v = 0; v < w; v++)
            if (dest_write[v] && int'(dest_tag[v*TW +: TW]) == tag) r = 0;
        return r;
    endfunction

    // Model update on every rising edge from the inputs held over the cycle.
    always @(posedge CLK) begin
        if (nRST) begin
            for (int r = 0; r < NPR; r++) begin
                m_table[r] = 1;
                for (int c = 0; c < NC; c++) m_ckpt[c][r] = 1;
            end
            for (int c = 0; c < NC; c++) m_valid[c] = 0;
            m_err = 0;
        end else begin
            bit err;
            err = 0;
            for (int r = 0; r < NPR; r++) comp[r] = 0;
            for (int b = 0; b < NB; b++)
                if (bus_valid[b]) comp[int'(bus_tag[b*TW +: TW])] = 1;
            for (int i = 0; i < DW; i++)
                for (int j = i + 1; j < DW; j++)
                    if (dest_write[i] && dest_write[j] &&
                        dest_tag[i*TW +: TW] == dest_tag[j*TW +: TW]) err = 1;
            for (int i = 0; i < NB; i++)
                for (int j = i + 1; j < NB; j++)
                    if (bus_valid[i] && bus_valid[j] &&
                        bus_tag[i*TW +: TW] == bus_tag[j*TW +: TW]) err = 1;
            if (restore_valid && !m_valid[int'(restore_index)]) err = 1;

            for (int r = 0; r < NPR; r++) nxt[r] = m_table[r];
            if (restore_valid) begin
                if (m_valid[int'(restore_index)])
                    for (int r = 0; r < NPR; r++)
                        nxt[r] = m_ckpt[int'(restore_index)][r] | comp[r];
            end else begin
                for (int r = 0; r < NPR; r++) nxt[r] = m_table[r] | comp[r];
                for (int w = 0; w < DW; w++)
                    if (dest_write[w]) nxt[int'(dest_tag[w*TW +: TW])] = 0;
            end

            for (int c = 0; c < NC; c++)
                for (int r = 0; r < NPR; r++)
                    m_ckpt[c][r] = m_ckpt[c][r] | comp[r];
            if (save_valid && !restore_valid) begin
                for (int r = 0; r < NPR; r++) m_ckpt[int'(save_index)][r] = nxt[r];
                m_valid[int'(save_index)] = 1;
            end

            for (int r = 0; r < NPR; r++) m_table[r] = nxt[r];
            m_err = err;
        end
    end

    // Compare process: every output against the model, each falling edge.
    always @(negedge CLK) begin
        if (check_en) begin
            checkOutput("DUT_error", DUT_error, m_err);
            for (int w = 0; w < DW; w++) begin
                checkOutput($sformatf("src0_ready_w%0d", w), src0_ready[w],
                            expReady(w, int'(src0_tag[w*TW +: TW])));
                checkOutput($sformatf("src1_ready_w%0d", w), src1_ready[w],
                            expReady(w, int'(src1_tag[w*TW +: TW])));
            end
        end
    end

    task automatic clearInputs;
        src0_tag = '0; src1_tag = '0; dest_write = '0; dest_tag = '0;
        bus_valid = '0; bus_tag = '0;
        save_valid = 0; save_index = '0; restore_valid = 0; restore_index = '0;
    endtask

    task automatic nextCycle;
        @(posedge CLK);
        #1;
        clearInputs();
    endtask

    task automatic setSrc(input int w, input int s, input int tag);
        if (s == 0) src0_tag[w*TW +: TW] = TW'(tag);
        else        src1_tag[w*TW +: TW] = TW'(tag);
    endtask

    task automatic setDest(input int w, input int tag);
        dest_write[w] = 1'b1;
        dest_tag[w*TW +: TW] = TW'(tag);
    endtask

    task automatic setBus(input int b, input int tag);
        bus_valid[b] = 1'b1;
        bus_tag[b*TW +: TW] = TW'(tag);
    endtask

    // Random traffic over a narrow tag range so collisions are common.
    task automatic applyStimulus;
        nRST = ($urandom_range(0, 399) == 0);
        for (int w = 0; w < DW; w++) begin
            setSrc(w, 0, $urandom_range(0, 15));
            setSrc(w, 1, $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) setDest(w, $urandom_range(0, 15));
        end
        for (int b = 0; b < NB; b++)
            if ($urandom_range(0, 2) == 0) setBus(b, $urandom_range(0, 15));
        save_valid    = ($urandom_range(0, 7) == 0);
        save_index    = CW'($urandom_range(0, NC - 1));
        restore_valid = ($urandom_range(0, 15) == 0);
        restore_index = CW'($urandom_range(0, NC - 1));
    endtask

    initial begin
        clearInputs();
        nRST = 1;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 0;
        check_en = 1;

        // Out of reset every tag reads ready.
        #2;
        checkOutput("reset_src0", src0_ready, 2'b11);
        checkOutput("reset_src1", src1_ready, 2'b11);
        checkOutput("reset_error", DUT_error, 0);

        // Clear 5, read it busy, then bypass a completion.
        nextCycle(); setDest(0, 5);
        nextCycle(); setSrc(0, 0, 5); setSrc(1, 0, 5);
        #2; checkOutput("tag5_busy", src0_ready, 2'b00);
        setBus(0, 5);
        #2; checkOutput("tag5_bypass", src0_ready, 2'b11);
        nextCycle(); setSrc(0, 0, 5); setSrc(1, 0, 5);
        #2; checkOutput("tag5_stays", src0_ready, 2'b11);

        // Older-way clear hides the tag from younger ways only.
        nextCycle(); setDest(0, 9); setSrc(1, 1, 9); setSrc(0, 0, 9);
        #2; checkOutput("older_clear_w1", src1_ready[1], 0);
        checkOutput("own_clear_w0", src0_ready[0], 1);
        nextCycle(); setBus(1, 9); setDest(0, 9); setSrc(0, 0, 9);
        #2; checkOutput("tag9_bypass", src0_ready[0], 1);
        nextCycle(); setSrc(0, 0, 9);
        #2; checkOutput("clear_wins_9", src0_ready[0], 0);

        // Checkpoint save/restore with a completion landing in between.
        nextCycle(); setDest(0, 12);
        nextCycle(); save_valid = 1; save_index = 2;
        nextCycle(); setDest(0, 13);
        nextCycle(); setBus(0, 12);
        nextCycle(); restore_valid = 1; restore_index = 2; setDest(0, 14); setSrc(0, 0, 13);
        #2; checkOutput("restore_read_13", src0_ready[0], 0);
        nextCycle(); setSrc(0, 0, 12); setSrc(0, 1, 13); setSrc(1, 0, 14);
        #2; checkOutput("restored_12", src0_ready[0], 1);
        checkOutput("restored_13", src1_ready[0], 1);
        checkOutput("ignored_clear_14", src0_ready[1], 1);

        // Restore from a never-saved slot.
        nextCycle(); setDest(0, 20);
        nextCycle(); restore_valid = 1; restore_index = 3;
        nextCycle(); setSrc(0, 0, 20); setSrc(1, 0, 12);
        #2; checkOutput("bad_restore_err", DUT_error, 1);
        checkOutput("bad_restore_hold", src0_ready, 2'b10);
        nextCycle();
        #2; checkOutput("err_pulse", DUT_error, 0);

        // Duplicate completion tags.
        nextCycle(); setDest(0, 7);
        nextCycle(); setBus(0, 7); setBus(1, 7);
        nextCycle(); setSrc(0, 0, 7);
        #2; checkOutput("dup_bus_err", DUT_error, 1);
        checkOutput("dup_bus_set7", src0_ready[0], 1);

        // Duplicate dest clears.
        nextCycle(); setDest(0, 30); setDest(1, 30);
        nextCycle();
        #2; checkOutput("dup_clear_err", DUT_error, 1);
        nextCycle();
        #2; checkOutput("dup_clear_pulse", DUT_error, 0);

        // Randomized traffic.
        repeat (3000) begin
            nextCycle();
            applyStimulus();
        end
        nextCycle();
        nRST = 0;
        @(posedge CLK);
        #1;
        check_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
